// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID register: drives a synchronous instruction
// memory, presents the ID instruction and its register fields, honours stall and redirect.
module fetch_stage #(
  parameter int              AW       = 16,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_data,
  output logic          id_valid,
  output logic [AW-1:0] id_pc,
  output logic [31:0]   id_instr,
  output logic [5:0]    id_rs1,
  output logic [4:0]    id_rs2,
  output logic [5:0]    id_rd
);

  // id_valid qualifies the ID slot for one cycle; there is no ready back-pressure
  // other than halt, which holds the slot (and pc) until the edge after it drops.
  logic [AW-1:0] pc;
  logic [AW-1:0] fetch_pc;
  logic          fetch_valid;
  logic [31:0]   hold_instr;
  logic          hold_valid;
  logic [31:0]   id_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      fetch_pc    <= '0;
      fetch_valid <= 1'b0;
      hold_valid  <= 1'b0;
      hold_instr  <= '0;
    end else if (br_taken) begin
      pc          <= br_target;
      fetch_valid <= 1'b0;
      hold_valid  <= 1'b0;
    end else if (halt) begin
      // The memory output moves on after the first stall edge, so capture it once.
      if (!hold_valid) begin
        hold_instr <= imem_data;
        hold_valid <= 1'b1;
      end
    end else begin
      fetch_pc    <= pc;
      fetch_valid <= 1'b1;
      pc          <= pc + AW'(4);
      hold_valid  <= 1'b0;
    end
  end

  assign imem_addr = pc;
  assign id_pc     = fetch_pc;
  assign id_valid  = fetch_valid;

  // Bubbles present an all-zero word so downstream hazard checks see no registers.
  assign id_word  = hold_valid ? hold_instr : imem_data;
  assign id_instr = fetch_valid ? id_word : 32'd0;
  assign id_rs1   = id_instr[11:6];
  assign id_rs2   = id_instr[16:12];
  assign id_rd    = id_instr[31] ? 6'd0 : id_instr[5:0];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID register of the pipelined core. It sits directly upstream of the hazard controller and feeds it the `rs1`/`rs2`/`rd` fields of the instruction in ID. It consumes that controller's `halt` to freeze the PC and the ID instruction. It also accepts branch redirects from EX and flushes the wrong-path instruction.

## Interface
- `AW`, 16: instruction-memory byte-address / PC width.
- `RESET_PC`, 0: PC value loaded on reset (AW bits, multiple of 4).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `halt` in 1: stall request from the hazard controller.
- `br_taken` in 1: redirect request from EX.
- `br_target` in AW: redirect address.
- `imem_addr` out AW: instruction-memory address. Equals `pc`, combinational from the register.
- `imem_data` in 32: synchronous memory read data. Returns `mem[addr]` one cycle after the address is presented.
- `id_valid` out 1: the ID slot holds a real instruction.
- `id_pc` out AW: PC of the ID instruction.
- `id_instr` out 32: ID instruction word.
- `id_rs1` out 6: `id_instr[11:6]`.
- `id_rs2` out 5: `id_instr[16:12]`.
- `id_rd` out 6: `id_instr[5:0]`. Forced to 0 when `id_instr[31]=1` (no-destination class).

## Operation
- State registers:
  - `pc`: next address to fetch.
  - `fetch_pc` / `fetch_valid`: the instruction whose data is on `imem_data` this cycle.
  - `hold_instr` / `hold_valid`: skid buffer that keeps the ID instruction while stalled.
- ID source:
  - `id_instr = hold_valid ? hold_instr : imem_data`.
  - `id_pc = fetch_pc`.
  - `id_valid = fetch_valid`.
- Whenever `id_valid=0`, `id_instr`, `id_rs1`, `id_rs2` and `id_rd` are all 0. A bubble therefore never creates a false hazard.
- Per-edge priority: reset > redirect > stall > advance.
  - **Reset** (`rst_n=0`): `pc<=RESET_PC`, `fetch_pc<=0`, `fetch_valid<=0`, `hold_valid<=0`, `hold_instr<=0`.
  - **Redirect** (`br_taken=1`): `pc<=br_target`, `fetch_valid<=0`, `hold_valid<=0`. The current ID instruction is flushed. `halt` is ignored this cycle.
  - **Stall** (`halt=1`, no redirect):
    - `pc` and `fetch_pc` hold.
    - If `hold_valid=0`: `hold_instr<=imem_data`, `hold_valid<=1`.
    - If `hold_valid=1`: the buffer is kept unchanged.
  - **Advance**: `fetch_pc<=pc`, `fetch_valid<=1`, `pc<=pc+4`, `hold_valid<=0`.
- PC arithmetic is modulo 2^AW. `pc+4` from `2^AW-4` wraps to 0; no flag is raised.
- `br_target` is used as given. Low-bit alignment is the producer's responsibility.

## Timing
- Reset values of outputs:
  - `imem_addr=RESET_PC`.
  - `id_valid=0`, `id_pc=0`, `id_instr=0`, `id_rs1=0`, `id_rs2=0`, `id_rd=0`.
- Fetch latency after reset release:
  - Release cycle: `imem_addr=RESET_PC`, ID invalid.
  - Next cycle: ID shows `mem[RESET_PC]`.
  - After that, one new instruction per cycle.
- Stall behaviour:
  - `halt` high in cycle N → ID content in N+1 equals ID content in N. `imem_addr` is unchanged.
  - After `halt` falls, the instruction at the held `pc` appears in ID the cycle after the first advance edge. No instruction is skipped or duplicated.
- Consecutive `halt` cycles hold indefinitely. `hold_instr` is captured only on the first stall cycle.
- Redirect timing:
  - `br_taken` in cycle N → `imem_addr=br_target` in N+1 with ID invalid.
  - `mem[br_target]` appears in ID in N+2. The penalty is exactly one bubble.
- `br_taken` and `halt` in the same cycle: the redirect wins and the hold buffer is cleared.
- `br_taken` while `id_valid=0`: same behaviour as above.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values at that edge.

## Test plan
- Reset with `RESET_PC=0x0100`, memory `mem[0x100+4k]=k`, no stalls → `imem_addr` = 0x100, 0x104, 0x108, …; `id_instr` = 0, 1, 2, … starting one cycle after release; `id_pc` tracks the instruction.
- Field decode: ID instruction `0x0001_F0C5` → `id_rs1=3`, `id_rs2=31`, `id_rd=5`. ID instruction `0x8000_0005` → `id_rd=0`. Bubble → all fields 0.
- Single `halt` with ID=instr@0x108 → ID shows instr@0x108 for 2 cycles, then 0x10C, 0x110. `imem_addr` holds 0x10C for exactly 2 cycles.
- Three-cycle `halt` followed by `br_taken` with target 0x200 in the cycle after `halt` falls → ID holds instr@0x108 for 4 cycles, then ID invalid for 1 cycle, then instr@0x200.
- `br_taken` and `halt` together, target 0x040 → next cycle `imem_addr=0x040` and `id_valid=0`. Next cycle ID = instr@0x040, with no stale hold data.
- `AW=8`, PC at 0xFC advancing → `imem_addr` wraps 0xFC→0x00, and ID sequence continues without a bubble. Asserting `rst_n=0` during a `halt` → next cycle `imem_addr=RESET_PC` and `id_valid=0`.
